// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin arbiter driving the select of an 8:1 x 4-bit data mux
//
// Grants one of eight requesters at a time and drives the mux select. A grant lasts
// while its request stays high, for at most HOLD_MAX cycles. On release the next
// owner is searched from just past the released index, so the handoff costs no
// idle cycle.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  synchronous active-low reset
//   req        in   8  request vector, req[i] high = requester i wants the mux
//   gnt        out  8  one-hot grant (registered), zero when idle
//   sel        out  3  mux select (registered), index of the set gnt bit
//   out_valid  out  1  registered, equals |gnt
//   busy       out  1  registered, high while a grant is active

module mux8_rr_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       out_valid,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

    state_t     state, state_n;
    logic [2:0] ptr, ptr_n;
    logic [3:0] hold_cnt, hold_n;
    logic [7:0] gnt_n;
    logic [2:0] sel_n;

    // Winner search. While granted, the search always starts just past the current
    // owner: it is only consumed on release, and the current owner then comes last,
    // which gives a sole requester an immediate re-grant.
    logic [2:0] search_base;
    logic [2:0] scan_idx;
    logic       win_found;
    logic [2:0] win_idx;

    always_comb begin
        search_base = (state == GRANT) ? sel + 3'd1 : ptr;
        scan_idx    = 3'd0;
        win_found   = 1'b0;
        win_idx     = 3'd0;
        for (int i = 0; i < 8; i++) begin
            scan_idx = search_base + 3'(i);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        gnt_n   = gnt;
        sel_n   = sel;
        case (state)
            IDLE: begin
                gnt_n = 8'h00;
                if (win_found) begin
                    gnt_n   = 8'h01 << win_idx;
                    sel_n   = win_idx;
                    hold_n  = 4'd0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (req[sel] && (hold_cnt < HOLD_LAST)) begin
                    hold_n = hold_cnt + 4'd1;
                end else begin
                    ptr_n  = sel + 3'd1;
                    hold_n = 4'd0;
                    if (win_found) begin
                        gnt_n = 8'h01 << win_idx;
                        sel_n = win_idx;
                    end else begin
                        gnt_n   = 8'h00;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            hold_cnt  <= 4'd0;
            gnt       <= 8'h00;
            sel       <= 3'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            hold_cnt  <= hold_n;
            gnt       <= gnt_n;
            sel       <= sel_n;
            out_valid <= |gnt_n;
            busy      <= (state_n == GRANT);
        end
    end

endmodule
